// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory bus between instruction fetch (IF) and load/store (D).
// One access at a time, D-first with a bounded D streak, and a per-access timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_err_o,
    output logic        hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    // Handshake: each requester holds req (level) until its 1-cycle valid pulse;
    // the bus holds bus_req_o and all bus_* fields stable until bus_ack_i or timeout.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  tmo;
    logic [SW-1:0]  streak;
    logic           owner_d;
    logic           if_elig;
    logic           d_elig;
    logic           grant_if;
    logic           grant_d;
    logic           done;
    logic           timed_out;
    logic [31:0]    result;

    // A requester whose completion pulse is visible this cycle is not re-granted.
    assign if_elig = if_req_i & ~if_valid_o;
    assign d_elig  = d_req_i & ~d_valid_o;
    assign hold_o  = d_req_i & ~d_valid_o;
    assign result  = (timed_out || bus_we_o) ? 32'h0 : bus_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (if_elig && (!d_elig || streak == SW'(MAX_D_STREAK))) begin
                    grant_if = 1'b1;
                end else if (d_elig) begin
                    grant_d = 1'b1;
                end
                if (grant_if || grant_d) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (bus_ack_i) begin
                    done = 1'b1;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo         <= '0;
            streak      <= '0;
            owner_d     <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            if_rdata_o  <= 32'h0;
            if_valid_o  <= 1'b0;
            if_err_o    <= 1'b0;
            d_rdata_o   <= 32'h0;
            d_valid_o   <= 1'b0;
            d_err_o     <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            if_err_o   <= 1'b0;
            d_valid_o  <= 1'b0;
            d_err_o    <= 1'b0;

            if (grant_if || grant_d) begin
                owner_d     <= grant_d;
                bus_req_o   <= 1'b1;
                bus_we_o    <= grant_d & d_we_i;
                bus_sel_o   <= (grant_d && d_we_i) ? d_sel_i : 4'hF;
                bus_addr_o  <= grant_d ? d_addr_i : if_addr_i;
                bus_wdata_o <= grant_d ? d_wdata_i : 32'h0;
                tmo         <= '0;
            end

            if (grant_if) begin
                streak <= '0;
            end else if (grant_d) begin
                // The streak only measures D grants that actually made IF wait.
                if (!if_req_i) begin
                    streak <= '0;
                end else if (streak != SW'(MAX_D_STREAK)) begin
                    streak <= streak + 1'b1;
                end
            end

            if (state == BUSY) begin
                if (done) begin
                    bus_req_o <= 1'b0;
                    if (owner_d) begin
                        d_valid_o <= 1'b1;
                        d_err_o   <= timed_out;
                        d_rdata_o <= result;
                    end else begin
                        if_valid_o <= 1'b1;
                        if_err_o   <= timed_out;
                        if_rdata_o <= result;
                    end
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, hand sequences for arbitration/reset corners,
// and random traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        if_err_o;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_sel = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        d_err_o;
    logic        hold_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.TIMEOUT(TMO), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_err_o(if_err_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o),
        .d_err_o(d_err_o), .hold_o(hold_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoring ----------------
    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Tracks the one in-flight access as a record plus its age in bus cycles.
    bit        m_busy, m_own_d, m_we, m_bus_req;
    bit [3:0]  m_sel;
    bit [31:0] m_addr, m_wdata;
    int        m_age, m_streak;
    bit        m_if_valid, m_d_valid, m_if_err, m_d_err;
    bit [31:0] m_if_rdata, m_d_rdata;
    bit        e_if, e_d, m_err;
    bit [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_own_d = 0; m_we = 0; m_bus_req = 0; m_sel = 0;
            m_addr = 0; m_wdata = 0; m_age = 0; m_streak = 0;
            m_if_valid = 0; m_d_valid = 0; m_if_err = 0; m_d_err = 0;
            m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            e_if = if_req && !m_if_valid;
            e_d  = d_req && !m_d_valid;
            m_if_valid = 0; m_d_valid = 0; m_if_err = 0; m_d_err = 0;
            if (!m_busy) begin
                if (e_if && (!e_d || m_streak == MAXS)) begin
                    m_busy = 1; m_own_d = 0; m_we = 0; m_sel = 4'hF;
                    m_addr = if_addr; m_wdata = 0; m_age = 0; m_streak = 0;
                end else if (e_d) begin
                    m_busy = 1; m_own_d = 1; m_we = d_we; m_sel = d_we ? d_sel : 4'hF;
                    m_addr = d_addr; m_wdata = d_wdata; m_age = 0;
                    m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                end
            end else begin
                m_age++;
                if (bus_ack || m_age == TMO) begin
                    m_res = (bus_ack && !m_we) ? bus_rdata : 32'h0;
                    m_err = !bus_ack;
                    if (m_own_d) begin
                        m_d_valid = 1; m_d_err = m_err; m_d_rdata = m_res;
                    end else begin
                        m_if_valid = 1; m_if_err = m_err; m_if_rdata = m_res;
                    end
                    m_busy = 0;
                end
            end
            m_bus_req = m_busy;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("if_resp", 192'({if_valid_o, if_err_o, if_rdata_o}),
                  192'({m_if_valid, m_if_err, m_if_rdata}));
            check("d_resp", 192'({d_valid_o, d_err_o, d_rdata_o}),
                  192'({m_d_valid, m_d_err, m_d_rdata}));
            check("hold", 192'(hold_o), 192'(d_req & ~m_d_valid));
            check("bus_req", 192'(bus_req_o), 192'(m_bus_req));
            if (m_bus_req) begin
                check("bus_fields",
                      192'({bus_we_o, bus_sel_o, bus_addr_o, (m_we ? bus_wdata_o : 32'h0)}),
                      192'({m_we, m_sel, m_addr, (m_we ? m_wdata : 32'h0)}));
            end
        end
    end

    // ---------------- table-driven single transactions ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_n;      // ack in this BUSY cycle (0 = never)
        logic [31:0] bus_rd;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_busy;   // cycles bus_req_o stays high
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int  busy_n;
        bit  seen;
        logic vld;
        busy_n = 0;
        seen = 0;
        step();
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_sel = v.sel; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (bus_req_o) begin
                busy_n++;
                if (busy_n == 1) begin
                    check($sformatf("vec%0d_bus", idx),
                          192'({bus_we_o, bus_sel_o, bus_addr_o, (v.we ? bus_wdata_o : 32'h0)}),
                          192'({(v.is_d & v.we), v.exp_sel, v.addr, (v.we ? v.wdata : 32'h0)}));
                end
                bus_ack = (busy_n == v.ack_n);
                bus_rdata = v.bus_rd;
            end else begin
                bus_ack = 0;
            end
            vld = v.is_d ? d_valid_o : if_valid_o;
            if (vld) begin
                seen = 1;
                check($sformatf("vec%0d_latency", idx), 192'(cyc), 192'(v.exp_busy + 1));
                check($sformatf("vec%0d_busy", idx), 192'(busy_n), 192'(v.exp_busy));
                if (v.is_d)
                    check($sformatf("vec%0d_resp", idx), 192'({d_err_o, d_rdata_o}),
                          192'({v.exp_err, v.exp_rdata}));
                else
                    check($sformatf("vec%0d_resp", idx), 192'({if_err_o, if_rdata_o}),
                          192'({v.exp_err, v.exp_rdata}));
                if_req = 0;
                d_req = 0;
                break;
            end
        end
        if (!seen) check($sformatf("vec%0d_no_valid", idx), 192'(0), 192'(1));
        bus_ack = 0;
        if_req = 0;
        d_req = 0;
        repeat (2) step();
    endtask

    // ---------------- main sequence ----------------
    int grants[$];
    int exp_grants[$];
    bit prev_req;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h10,  32'h0,      3, 32'h00500093, 32'h00500093, 1'b0, 3, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h100, 32'h0000A5A5, 1, 32'h12345678, 32'h0,      1'b0, 1, 4'h3};
        vecs[2] = '{1'b1, 1'b0, 4'h1, 32'h200, 32'h0,      2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 4'hF};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h204, 32'h0,      0, 32'h55555555, 32'h0,        1'b1, TMO, 4'hF};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h14,  32'h0,      0, 32'h77777777, 32'h0,        1'b1, TMO, 4'hF};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h18,  32'h0,    TMO, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, TMO, 4'hF};
        vecs[6] = '{1'b1, 1'b1, 4'hC, 32'h208, 32'h13572468, TMO, 32'h99999999, 32'h0,    1'b0, TMO, 4'hC};
        vecs[7] = '{1'b1, 1'b0, 4'h0, 32'h20C, 32'h0,      1, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 1, 4'hF};

        // reset state
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              192'({if_rdata_o, if_valid_o, if_err_o, d_rdata_o, d_valid_o, d_err_o, hold_o,
                    bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}), 192'(0));
        step();
        rst_n = 1;
        chk_en = 1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // IF and D raised together: D first, IF granted in the d_valid cycle
        step();
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h400;
        step();
        check("t2_d_first", 192'({bus_req_o, bus_addr_o, hold_o}), 192'({1'b1, 32'h400, 1'b1}));
        bus_ack = 1; bus_rdata = 32'h11112222;
        step();
        check("t2_d_done", 192'({d_valid_o, d_rdata_o, hold_o}), 192'({1'b1, 32'h11112222, 1'b0}));
        bus_ack = 0; d_req = 0;
        step();
        check("t2_if_next", 192'({bus_req_o, bus_addr_o}), 192'({1'b1, 32'h20}));
        bus_ack = 1; bus_rdata = 32'h33334444;
        step();
        check("t2_if_done", 192'({if_valid_o, if_rdata_o}), 192'({1'b1, 32'h33334444}));
        bus_ack = 0; if_req = 0;
        repeat (2) step();

        // D streak: IF skips each d_valid cycle, so the streak builds to the limit
        exp_grants = '{1, 1, 1, 1, 0, 1};
        grants.delete();
        prev_req = 0;
        step();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int cyc = 0; cyc < 80 && grants.size() < 6; cyc++) begin
            step();
            if_req = !d_valid_o;
            bus_ack = bus_req_o;
            if (bus_req_o && !prev_req) grants.push_back(bus_addr_o == 32'h300 ? 1 : 0);
            prev_req = bus_req_o;
        end
        if (grants.size() < 6) check("t3_grant_count", 192'(grants.size()), 192'(6));
        foreach (grants[i]) check($sformatf("t3_grant%0d", i), 192'(grants[i]), 192'(exp_grants[i]));
        // requests dropped mid-access; the in-flight D access still completes
        if_req = 0; d_req = 0;
        repeat (12) begin
            step();
            bus_ack = bus_req_o;
        end
        bus_ack = 0;

        // reset in the middle of an access
        step();
        d_req = 1; d_we = 0; d_addr = 32'h500;
        step();
        step();
        check("t6_busy", 192'(bus_req_o), 192'(1));
        #3 rst_n = 0;
        #1 check("t6_async_drop", 192'(bus_req_o), 192'(0));
        d_req = 0;
        step();
        step();
        rst_n = 1;
        repeat (6) begin
            step();
            check("t6_quiet", 192'({d_valid_o, if_valid_o, bus_req_o}), 192'(0));
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            if (if_req) begin
                if (if_valid_o) begin
                    if_req = ($urandom_range(0, 1) == 1);
                    if_addr = $urandom;
                end else if ($urandom_range(0, 19) == 0) begin
                    if_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = $urandom;
            end
            if (d_req) begin
                if (d_valid_o) begin
                    d_req = ($urandom_range(0, 1) == 1);
                    d_we = $urandom_range(0, 1) == 1; d_sel = 4'($urandom);
                    d_addr = $urandom; d_wdata = $urandom;
                end else if ($urandom_range(0, 19) == 0) begin
                    d_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = $urandom_range(0, 1) == 1; d_sel = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            bus_ack = bus_req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus_rdata = $urandom;
        end

        if_req = 0; d_req = 0;
        repeat (12) begin
            step();
            bus_ack = bus_req_o;
        end
        bus_ack = 0;
        step();
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // overall time bound
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
